// File: rtl/cond_pkg.sv
// Shared definitions for the condition-code unit: flag bit positions,
// condition-code encodings, ALU operation codes and the per-op flag update mask.
package cond_pkg;

  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

  localparam logic [3:0] CC_EQ = 4'd0;
  localparam logic [3:0] CC_NE = 4'd1;
  localparam logic [3:0] CC_CS = 4'd2;
  localparam logic [3:0] CC_CC = 4'd3;
  localparam logic [3:0] CC_HI = 4'd4;
  localparam logic [3:0] CC_LS = 4'd5;
  localparam logic [3:0] CC_GT = 4'd6;
  localparam logic [3:0] CC_LE = 4'd7;
  localparam logic [3:0] CC_FS = 4'd8;
  localparam logic [3:0] CC_FC = 4'd9;
  localparam logic [3:0] CC_LO = 4'd10;
  localparam logic [3:0] CC_HS = 4'd11;
  localparam logic [3:0] CC_LT = 4'd12;
  localparam logic [3:0] CC_GE = 4'd13;
  localparam logic [3:0] CC_UC = 4'd14;
  localparam logic [3:0] CC_NV = 4'd15;

  localparam logic [4:0] OP_CMP  = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_ADDU = 5'd4;
  localparam logic [4:0] OP_SUB  = 5'd5;
  localparam logic [4:0] OP_SUBC = 5'd6;

  // Set bits mark flags written by this op; cleared bits hold their value.
  function automatic logic [4:0] upd_mask(input logic [4:0] op);
    logic [4:0] m;
    m = '0;
    case (op)
      OP_CMP: begin
        m[FLAG_N] = 1'b1;
        m[FLAG_Z] = 1'b1;
        m[FLAG_L] = 1'b1;
      end
      OP_ADD, OP_SUB, OP_SUBC: begin
        m[FLAG_C] = 1'b1;
        m[FLAG_F] = 1'b1;
      end
      OP_ADDU: m[FLAG_C] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational condition evaluator: (flags, condition code) -> condition true.
// Also used by the Scond write-back path.
module cond_eval
  import cond_pkg::*;
(
  input  logic [4:0] i_flags,
  input  logic [3:0] i_cond,
  output logic       o_true
);

  logic w_n, w_z, w_f, w_l, w_c;

  assign w_n = i_flags[FLAG_N];
  assign w_z = i_flags[FLAG_Z];
  assign w_f = i_flags[FLAG_F];
  assign w_l = i_flags[FLAG_L];
  assign w_c = i_flags[FLAG_C];

  always_comb begin
    o_true = 1'b0;
    case (i_cond)
      CC_EQ: o_true = w_z;
      CC_NE: o_true = !w_z;
      CC_CS: o_true = w_c;
      CC_CC: o_true = !w_c;
      CC_HI: o_true = w_l;
      CC_LS: o_true = !w_l;
      CC_GT: o_true = w_n;
      CC_LE: o_true = !w_n;
      CC_FS: o_true = w_f;
      CC_FC: o_true = !w_f;
      CC_LO: o_true = !w_l && !w_z;
      CC_HS: o_true = w_l || w_z;
      CC_LT: o_true = !w_n && !w_z;
      CC_GE: o_true = w_n || w_z;
      CC_UC: o_true = 1'b1;
      CC_NV: o_true = 1'b0;
      default: o_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_code_unit.sv
// Status flag register and registered condition bus for the controller.
// Define COND_PSR_ACCESS_EN to add direct flag load/read ports (psrWrite/psrIn/psrOut).
module cond_code_unit
  import cond_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             codesComputed,
  input  logic [4:0]       aluOp,
  input  logic [4:0]       aluFlags,
  input  logic [3:0]       condField,
  output logic [WIDTH-1:0] conCodesOut,
  output logic             carryOut
`ifdef COND_PSR_ACCESS_EN
  ,
  input  logic             psrWrite,
  input  logic [4:0]       psrIn,
  output logic [4:0]       psrOut
`endif
);

  logic [4:0]       r_flags;
  logic [WIDTH-1:0] r_con;
  logic [4:0]       w_mask;
  logic [4:0]       w_flags_upd;
  logic             w_cond_true;

  assign w_mask      = upd_mask(aluOp);
  assign w_flags_upd = (aluFlags & w_mask) | (r_flags & ~w_mask);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= '0;
`ifdef COND_PSR_ACCESS_EN
    end else if (psrWrite) begin
      r_flags <= psrIn;
`endif
    end else if (codesComputed) begin
      r_flags <= w_flags_upd;
    end
  end

  cond_eval u_cond_eval (
    .i_flags (r_flags),
    .i_cond  (condField),
    .o_true  (w_cond_true)
  );

  // Condition uses pre-update flags, so a flag change reaches the bus one edge later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_con <= '0;
    end else begin
      r_con <= {{(WIDTH-6){1'b0}}, r_flags, w_cond_true};
    end
  end

  assign conCodesOut = r_con;
  assign carryOut    = r_flags[FLAG_C];

`ifdef COND_PSR_ACCESS_EN
  assign psrOut = r_flags;
`endif

endmodule

// File: tb/tb_cond_code_unit.sv
// Self-checking bench for cond_code_unit: directed steps then random traffic
// against a flag/condition reference model.
module tb_cond_code_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        codesComputed;
  logic [4:0]  aluOp;
  logic [4:0]  aluFlags;
  logic [3:0]  condField;
  logic [15:0] conCodesOut;
  logic        carryOut;
`ifdef COND_PSR_ACCESS_EN
  logic        psrWrite;
  logic [4:0]  psrIn;
  logic [4:0]  psrOut;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // model state: flags as {N,Z,F,L,C} and the registered bus
  logic [4:0]  m_flags;
  logic [15:0] m_con;

  cond_code_unit #(.WIDTH(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .codesComputed (codesComputed),
    .aluOp         (aluOp),
    .aluFlags      (aluFlags),
    .condField     (condField),
    .conCodesOut   (conCodesOut),
    .carryOut      (carryOut)
`ifdef COND_PSR_ACCESS_EN
    ,
    .psrWrite      (psrWrite),
    .psrIn         (psrIn),
    .psrOut        (psrOut)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic ref_cond(input logic [4:0] f, input logic [3:0] cc);
    logic n, z, fl, l, c;
    {n, z, fl, l, c} = f;
    case (cc)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return l;
      4'd5:  return !l;
      4'd6:  return n;
      4'd7:  return !n;
      4'd8:  return fl;
      4'd9:  return !fl;
      4'd10: return !l && !z;
      4'd11: return l || z;
      4'd12: return !n && !z;
      4'd13: return n || z;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [4:0] ref_next(input logic [4:0] f, input logic [4:0] op,
                                          input logic [4:0] a);
    logic n, z, fl, l, c;
    {n, z, fl, l, c} = f;
    case (op)
      5'd0: begin n = a[4]; z = a[3]; l = a[1]; end
      5'd3, 5'd5, 5'd6: begin fl = a[2]; c = a[0]; end
      5'd4: c = a[0];
      default: ;
    endcase
    return {n, z, fl, l, c};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge with model update; returns 1 ns after the edge.
  task automatic tick();
    logic [4:0]  nf;
    logic [15:0] nc;
    nc = {10'b0, m_flags, ref_cond(m_flags, condField)};
    nf = codesComputed ? ref_next(m_flags, aluOp, aluFlags) : m_flags;
`ifdef COND_PSR_ACCESS_EN
    if (psrWrite) nf = psrIn;
`endif
    if (reset) begin nf = '0; nc = '0; end
    @(posedge clk);
    #1;
    m_flags = nf;
    m_con   = nc;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_carry"}, 32'(carryOut), 32'(m_flags[0]));
    check({tag, "_con"}, 32'(conCodesOut), 32'(m_con));
  endtask

  task automatic strobe(input logic [4:0] op, input logic [4:0] a);
    codesComputed = 1'b1; aluOp = op; aluFlags = a;
    tick();
    codesComputed = 1'b0;
  endtask

  initial begin
    reset = 1'b1; codesComputed = 1'b0; aluOp = '0; aluFlags = '0; condField = '0;
`ifdef COND_PSR_ACCESS_EN
    psrWrite = 1'b0; psrIn = '0;
`endif
    m_flags = '0; m_con = '0;
    tick(); tick();
    check_state("reset");
    reset = 1'b0;

    // CMP from zero: N,Z,L written, C,F held
    strobe(5'd0, 5'b11111);
    check("cmp_carry", 32'(carryOut), 32'd0);
    tick();
    check("cmp_eq_con", 32'(conCodesOut), 32'h0035);
    check_state("cmp");

    // ADD writes C,F
    strobe(5'd3, 5'b00101);
    check("add_carry", 32'(carryOut), 32'd1);
    tick();
    check("add_con", 32'(conCodesOut), 32'h003F);

    // async reset mid-cycle with all flags set
    #2;
    reset = 1'b1;
    #1;
    check("arst_con", 32'(conCodesOut), 32'd0);
    check("arst_carry", 32'(carryOut), 32'd0);
    m_flags = '0; m_con = '0;
    tick();
    reset = 1'b0;
    check_state("arst_hold");

    // unlisted op leaves flags alone
    strobe(5'd0, 5'b11111);
    strobe(5'd1, 5'b00101);
    tick();
    check("and_flags", 32'(conCodesOut[5:1]), 32'b11010);
    check_state("and");

    // condition sweep over fixed flag patterns
    foreach (m_flags[i]) ; // no-op keeps model declared ordering explicit
    begin
      logic [4:0] pats [4];
      pats = '{5'b00000, 5'b01000, 5'b00010, 5'b10000};
      for (int p = 0; p < 4; p++) begin
        strobe(5'd0, pats[p]);
        strobe(5'd3, pats[p]);
        check($sformatf("pat%0d_carry", p), 32'(carryOut), 32'(pats[p][0]));
        for (int cc = 0; cc < 16; cc++) begin
          condField = 4'(cc);
          tick();
          check($sformatf("sweep_p%0d_cc%0d", p, cc), 32'(conCodesOut), 32'(m_con));
          if (cc == 14) check($sformatf("uc_p%0d", p), 32'(conCodesOut[0]), 32'd1);
          if (cc == 15) check($sformatf("nv_p%0d", p), 32'(conCodesOut[0]), 32'd0);
        end
      end
    end

`ifdef COND_PSR_ACCESS_EN
    psrWrite = 1'b1; psrIn = 5'b10101;
    strobe(5'd0, 5'b01010);
    psrWrite = 1'b0;
    check("psr_out", 32'(psrOut), 32'b10101);
    check_state("psr");
`endif

    // random traffic
    for (int k = 0; k < 300; k++) begin
      codesComputed = 1'($urandom_range(0, 1));
      aluOp     = 5'($urandom_range(0, 7));
      aluFlags  = 5'($urandom);
      condField = 4'($urandom);
`ifdef COND_PSR_ACCESS_EN
      psrWrite = ($urandom_range(0, 7) == 0);
      psrIn    = 5'($urandom);
`endif
      tick();
      check($sformatf("rnd%0d", k), {15'b0, carryOut, conCodesOut},
            {15'b0, m_flags[0], m_con});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
